tnn_feature_loader: RTL and testbench

TNN_FEATURE_LOADER -- requirements
Module: tnn_feature_loader

---
 rtl/tnn_feature_loader.sv | 97 +++++++++
 tb/tb_tnn_feature_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tnn_feature_loader.sv
// tnn_feature_loader: streams quantised features into a register vector, runs one classifier evaluation, hands back the class bit
module tnn_feature_loader #(
    parameter int NFEAT = 7,
    parameter int FW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [FW-1:0] s_data,
    input  logic          s_last,
    output logic [FW-1:0] feat_a,
    output logic [FW-1:0] feat_b,
    output logic [FW-1:0] feat_c,
    output logic [FW-1:0] feat_d,
    output logic [FW-1:0] feat_e,
    output logic [FW-1:0] feat_f,
    output logic [FW-1:0] feat_g,
    input  logic          core_out,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_class,
    output logic          err_frame
);
    localparam int IW = NFEAT > 1 ? $clog2(NFEAT) : 1;
    localparam int NS = NFEAT < 7 ? 7 : NFEAT;
    localparam logic [IW-1:0] LAST_IDX = IW'(NFEAT - 1);
    typedef enum logic [1:0] {LOAD, EVAL, OUT, DRAIN} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [FW-1:0] feat_q [NS];
    logic          m_class_q;
    logic          err_q, err_d;
    logic          xfer, wr;
    assign s_ready   = (state_q == LOAD) || (state_q == DRAIN);
    assign m_valid   = state_q == OUT;
    assign m_class   = m_class_q;
    assign err_frame = err_q;
    assign xfer      = s_valid && s_ready;
    assign feat_a    = feat_q[0];
    assign feat_b    = feat_q[1];
    assign feat_c    = feat_q[2];
    assign feat_d    = feat_q[3];
    assign feat_e    = feat_q[4];
    assign feat_f    = feat_q[5];
    assign feat_g    = feat_q[6];
    // next state: framing checks on every LOAD transfer, discard until s_last in DRAIN
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        wr      = 1'b0;
        case (state_q)
            LOAD: begin
                if (xfer) begin
                    wr = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = s_last ? EVAL : DRAIN;
                        err_d   = !s_last;
                    end else if (s_last) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            EVAL:    state_d = OUT;
            OUT:     state_d = m_ready ? LOAD : OUT;
            DRAIN:   state_d = (xfer && s_last) ? LOAD : DRAIN;
            default: state_d = LOAD;
        endcase
    end
    // control registers; the class bit is sampled on the single EVAL cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOAD;
            idx_q     <= '0;
            err_q     <= 1'b0;
            m_class_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            if (state_q == EVAL) m_class_q <= core_out;
        end
    end
    // feature vector: written only by LOAD transfers, so it holds through EVAL, OUT and DRAIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) feat_q[i] <= '0;
        end else if (wr) begin
            feat_q[idx_q] <= s_data;
        end
    end
endmodule

// File: tb/tb_tnn_feature_loader.sv
// tb_tnn_feature_loader: directed vector table plus reset sequences for the feature loader
module tb_tnn_feature_loader;
    logic       clk = 0, rst = 1, s_valid = 0, s_last = 0, m_ready = 1;
    logic [1:0] s_data = 0;
    logic       s_ready, core_out, m_valid, m_class, err_frame;
    logic [1:0] feat_a, feat_b, feat_c, feat_d, feat_e, feat_f, feat_g;
    int tests = 0, fails = 0;
    int res_cnt = 0, err_cnt = 0, xfer_cnt = 0, err_pos = 0;

    typedef struct {
        int f[9];
        int n;
        int hold;
        bit bub;
        bit res;
        bit cls;
        int errpos;
    } vec_t;
    vec_t vt[9];

    tnn_feature_loader #(.NFEAT(7), .FW(2)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .feat_a(feat_a), .feat_b(feat_b), .feat_c(feat_c), .feat_d(feat_d),
        .feat_e(feat_e), .feat_f(feat_f), .feat_g(feat_g), .core_out(core_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    function automatic logic cls(input int a, b, c, d, e, f, g);
        return (a + c + e + g) > (b + d + f);
    endfunction

    assign core_out = cls(feat_a, feat_b, feat_c, feat_d, feat_e, feat_f, feat_g);

    function automatic logic [13:0] expf(input vec_t v);
        return {2'(v.f[0]), 2'(v.f[1]), 2'(v.f[2]), 2'(v.f[3]), 2'(v.f[4]), 2'(v.f[5]), 2'(v.f[6])};
    endfunction

    function automatic logic [13:0] featv();
        return {feat_a, feat_b, feat_c, feat_d, feat_e, feat_f, feat_g};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (err_frame) begin
                err_cnt++;
                err_pos = xfer_cnt;
            end
            if (m_valid && m_ready) res_cnt++;
            if (s_valid && s_ready) xfer_cnt++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input int f[9], input int n, input bit lst, input bit bub);
        for (int i = 0; i < n; i++) begin
            if (bub) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 0;
                    s_data  = 2'($urandom);
                    s_last  = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
            s_valid = 1;
            s_data  = 2'(f[i]);
            s_last  = lst && (i == n - 1);
            begin
                int w = 0;
                while (!s_ready && w < 50) begin
                    @(posedge clk); #1;
                    w++;
                end
                if (w >= 50) chk("sready_timeout", 0, 1);
            end
            @(posedge clk); #1;
        end
        s_valid = 0;
        s_data  = 2'($urandom);
        s_last  = 1'($urandom);
    endtask

    task automatic run_vec(input vec_t v);
        int r0 = res_cnt, e0 = err_cnt, x0 = xfer_cnt;
        m_ready = (v.hold == 0);
        send(v.f, v.n, 1, v.bub);
        if (v.res) begin
            chk("eval_no_valid", m_valid, 0);
            @(posedge clk); #1;
            chk("out_valid", m_valid, 1);
            chk("out_sready", s_ready, 0);
            chk("class", m_class, v.cls);
            chk("feat_vec", featv(), expf(v));
            if (v.hold > 0) begin
                repeat (v.hold) begin
                    @(posedge clk); #1;
                    chk("hold_valid", m_valid, 1);
                    chk("hold_class", m_class, v.cls);
                    chk("hold_sready", s_ready, 0);
                end
                m_ready = 1;
            end
            @(posedge clk); #1;
            chk("valid_drop", m_valid, 0);
        end else begin
            repeat (3) @(posedge clk);
            #1;
        end
        chk("results", res_cnt - r0, int'(v.res));
        chk("errs", err_cnt - e0, int'(v.errpos != 0));
        if (v.errpos != 0) chk("err_pos", err_pos - x0, v.errpos);
        if (v.errpos == 7) chk("drain_keep", featv(), expf(v));
        chk("sready_idle", s_ready, 1);
    endtask

    initial begin
        vec_t g;
        int r0, e0;
        vt[0] = '{'{1, 2, 0, 0, 2, 0, 3, 0, 0}, 7, 0, 0, 1, 1, 0};
        vt[1] = '{'{1, 2, 0, 0, 2, 0, 3, 0, 0}, 7, 5, 0, 1, 1, 0};
        vt[2] = '{'{3, 3, 3, 0, 0, 0, 0, 0, 0}, 3, 0, 0, 0, 0, 3};
        vt[3] = '{'{0, 3, 1, 2, 0, 3, 1, 0, 0}, 7, 0, 0, 1, 0, 0};
        vt[4] = '{'{2, 2, 2, 2, 2, 2, 2, 1, 1}, 9, 0, 0, 0, 0, 7};
        vt[5] = '{'{3, 0, 3, 0, 3, 0, 0, 0, 0}, 7, 0, 0, 1, 1, 0};
        vt[6] = '{'{0, 3, 1, 2, 0, 3, 1, 0, 0}, 7, 0, 1, 1, 0, 0};
        vt[7] = '{'{1, 2, 0, 0, 2, 0, 3, 0, 0}, 7, 2, 1, 1, 1, 0};
        vt[8] = '{'{1, 1, 1, 1, 1, 1, 0, 0, 0}, 7, 0, 0, 1, 0, 0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_feat", featv(), 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mclass", m_class, 0);
        chk("rst_err", err_frame, 0);
        rst = 0;
        @(posedge clk); #1;
        chk("rst_sready", s_ready, 1);
        for (int k = 0; k < 9; k++) run_vec(vt[k]);
        r0 = res_cnt;
        e0 = err_cnt;
        send(vt[0].f, 4, 0, 0);
        rst = 1;
        #2;
        chk("mid_rst_feat", featv(), 0);
        chk("mid_rst_mvalid", m_valid, 0);
        chk("mid_rst_mclass", m_class, 0);
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_err", err_cnt - e0, 0);
        chk("mid_rst_sready", s_ready, 1);
        run_vec(vt[3]);
        r0 = res_cnt;
        e0 = err_cnt;
        m_ready = 0;
        send(vt[0].f, 7, 1, 0);
        @(posedge clk); #1;
        chk("out_before_rst", m_valid, 1);
        rst = 1;
        #2;
        chk("out_rst_mvalid", m_valid, 0);
        chk("out_rst_mclass", m_class, 0);
        chk("out_rst_feat", featv(), 0);
        @(posedge clk); #1;
        rst = 0;
        m_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("out_rst_results", res_cnt - r0, 0);
        chk("out_rst_errs", err_cnt - e0, 0);
        g = vt[5];
        run_vec(g);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
